// File: rtl/icache_read_arbiter_pkg.sv
// Shared fetch-unit types for the I-cache read-port arbiter: owner tag,
// line geometry and the default starvation limit.
package FetchUnitTypes;

    localparam int PHY_ADDR_WIDTH           = 32;
    localparam int ICACHE_LINE_OFFSET_WIDTH = 4;
    localparam int ICACHE_ARB_STARVE_LIMIT  = 8;

    // Which requester owned the read port in the previous cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_PF    = 2'd2
    } IcacheArbOwner;

endpackage

// File: rtl/icache_read_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles the prefetcher lost arbitration.
// sat flags that the counter has reached LIMIT and the prefetcher is owed a win.
module icache_arb_starve_counter
    import FetchUnitTypes::*;
#(
    parameter int LIMIT = ICACHE_ARB_STARVE_LIMIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    input  logic                         clr,
    output logic [$clog2(LIMIT+1)-1:0]   count,
    output logic                         sat
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    // Clear wins over increment; hold once saturated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == LIMIT_V);

endmodule

// File: rtl/icache_read_arbiter.sv
// Arbitrates the single I-cache read port between fetch and the next-line
// prefetcher, drops prefetches to a line fetch has just read or is reading,
// and steers the one-cycle-later hit back to the previous owner.
// Optional feature: ICACHE_ARB_ANTI_STARVE_EN enables the prefetch
// starvation guard; without it fetch has strict priority.
module icache_read_arbiter
    import FetchUnitTypes::*;
#(
    parameter int ADDR_WIDTH        = PHY_ADDR_WIDTH,
    parameter int LINE_OFFSET_WIDTH = ICACHE_LINE_OFFSET_WIDTH,
    parameter int STARVE_LIMIT      = ICACHE_ARB_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    output logic                  fetchGrant,
    output logic                  fetchRespValid,
    input  logic                  pfReq,
    input  logic [ADDR_WIDTH-1:0] pfAddr,
    output logic                  pfGrant,
    output logic                  pfDropped,
    output logic                  pfRespValid,
    output logic                  icRE,
    output logic [ADDR_WIDTH-1:0] icReadAddrIn,
    input  logic                  icReadHit,
    output logic                  respHit
);

    localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET_WIDTH;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    IcacheArbOwner     owner;
    logic [LINE_W-1:0] lastLine;
    logic              lastLineValid;
    logic [CNT_W-1:0]  starveCnt;
    logic              starveSat;

    logic [LINE_W-1:0] fetchLine;
    logic [LINE_W-1:0] pfLine;
    logic              pfHitsLast;
    logic              pfHitsFetch;

    assign fetchLine   = fetchAddr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
    assign pfLine      = pfAddr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];
    assign pfHitsLast  = lastLineValid && (pfLine == lastLine);
    assign pfHitsFetch = (pfLine == fetchLine);

`ifdef ICACHE_ARB_ANTI_STARVE_EN
    logic starveInc;
    logic starveClr;

    // Only a genuinely lost, non-redundant request counts towards starvation.
    assign starveInc = pfReq && !pfGrant && !pfDropped && !flush;
    assign starveClr = pfGrant || !pfReq || flush;

    icache_arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (starveInc),
        .clr   (starveClr),
        .count (starveCnt),
        .sat   (starveSat)
    );
`else
    localparam logic [CNT_W-1:0] STARVE_LIMIT_V = CNT_W'(STARVE_LIMIT);

    // No guard: the count is pinned at zero, so saturation never occurs.
    assign starveCnt = '0;
    assign starveSat = (starveCnt == STARVE_LIMIT_V);
`endif

    // Grant selection: starved prefetch first, then fetch, then prefetch.
    // The starve check only looks at lastLine, since fetch is not granted
    // when the prefetcher takes its owed cycle.
    always_comb begin
        fetchGrant = 1'b0;
        pfGrant    = 1'b0;
        pfDropped  = 1'b0;
        if (rst && !flush) begin
            if (starveSat && pfReq && !pfHitsLast) begin
                pfGrant = 1'b1;
            end else if (fetchReq) begin
                fetchGrant = 1'b1;
                pfDropped  = pfReq && (pfHitsLast || pfHitsFetch);
            end else if (pfReq) begin
                if (pfHitsLast) begin
                    pfDropped = 1'b1;
                end else begin
                    pfGrant = 1'b1;
                end
            end
        end
    end

    assign icRE         = fetchGrant | pfGrant;
    assign icReadAddrIn = pfGrant ? pfAddr : fetchAddr;

    // Owner tag and lastLine validity; flush forgets the last fetched line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner         <= OWN_NONE;
            lastLineValid <= 1'b0;
        end else begin
            if (fetchGrant) begin
                owner <= OWN_FETCH;
            end else if (pfGrant) begin
                owner <= OWN_PF;
            end else begin
                owner <= OWN_NONE;
            end
            if (flush) begin
                lastLineValid <= 1'b0;
            end else if (fetchGrant) begin
                lastLineValid <= 1'b1;
            end
        end
    end

    // Line captured on every fetch grant; qualified by lastLineValid.
    always_ff @(posedge clk) begin
        if (fetchGrant) begin
            lastLine <= fetchLine;
        end
    end

    // A flush or reset in the response cycle discards the returning result.
    assign fetchRespValid = rst && !flush && (owner == OWN_FETCH);
    assign pfRespValid    = rst && !flush && (owner == OWN_PF);
    assign respHit        = icReadHit;

endmodule

// File: tb/tb_icache_read_arbiter.sv
// Directed testbench for icache_read_arbiter: reset, fetch priority,
// redundant-prefetch drop, starvation guard, flush, mid-run reset and
// alternating back-to-back grants.
module tb_icache_read_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fetchReq;
    logic [AW-1:0] fetchAddr;
    logic          fetchGrant;
    logic          fetchRespValid;
    logic          pfReq;
    logic [AW-1:0] pfAddr;
    logic          pfGrant;
    logic          pfDropped;
    logic          pfRespValid;
    logic          icRE;
    logic [AW-1:0] icReadAddrIn;
    logic          icReadHit;
    logic          respHit;

    int cmp_cnt = 0;
    int err_cnt = 0;

    icache_read_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fetchReq       (fetchReq),
        .fetchAddr      (fetchAddr),
        .fetchGrant     (fetchGrant),
        .fetchRespValid (fetchRespValid),
        .pfReq          (pfReq),
        .pfAddr         (pfAddr),
        .pfGrant        (pfGrant),
        .pfDropped      (pfDropped),
        .pfRespValid    (pfRespValid),
        .icRE           (icRE),
        .icReadAddrIn   (icReadAddrIn),
        .icReadHit      (icReadHit),
        .respHit        (respHit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetchReq = 1'b0;
        pfReq    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; icReadHit = 1'b0;
        fetchReq = 1'b1; fetchAddr = 32'h0000_1000;
        pfReq = 1'b1; pfAddr = 32'h0000_2000;
        tick(); tick();
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b0) begin err_cnt++; $display("FAIL rst_fetchGrant got %0h want 0", fetchGrant); end
        cmp_cnt++; if (pfGrant !== 1'b0) begin err_cnt++; $display("FAIL rst_pfGrant got %0h want 0", pfGrant); end
        cmp_cnt++; if (icRE !== 1'b0) begin err_cnt++; $display("FAIL rst_icRE got %0h want 0", icRE); end
        cmp_cnt++; if (fetchRespValid !== 1'b0) begin err_cnt++; $display("FAIL rst_fetchRespValid got %0h want 0", fetchRespValid); end
        cmp_cnt++; if (pfRespValid !== 1'b0) begin err_cnt++; $display("FAIL rst_pfRespValid got %0h want 0", pfRespValid); end
        tick();
        rst = 1'b1;
        idle();
        #1;
        cmp_cnt++; if (fetchRespValid !== 1'b0) begin err_cnt++; $display("FAIL rst_post_fetchRespValid got %0h want 0", fetchRespValid); end
        cmp_cnt++; if (dut.starveCnt !== 4'd0) begin err_cnt++; $display("FAIL rst_starveCnt got %0d want 0", dut.starveCnt); end
        tick();
    endtask

    task automatic test_fetch_priority();
        fetchReq = 1'b1; fetchAddr = 32'h0000_1000;
        pfReq = 1'b1; pfAddr = 32'h0000_2000;
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b1) begin err_cnt++; $display("FAIL fp_fetchGrant got %0h want 1", fetchGrant); end
        cmp_cnt++; if (pfGrant !== 1'b0) begin err_cnt++; $display("FAIL fp_pfGrant got %0h want 0", pfGrant); end
        cmp_cnt++; if (icReadAddrIn !== 32'h0000_1000) begin err_cnt++; $display("FAIL fp_addr got %0h want 1000", icReadAddrIn); end
        cmp_cnt++; if (pfDropped !== 1'b0) begin err_cnt++; $display("FAIL fp_pfDropped got %0h want 0", pfDropped); end
        cmp_cnt++; if (icRE !== 1'b1) begin err_cnt++; $display("FAIL fp_icRE got %0h want 1", icRE); end
        tick();
        idle(); icReadHit = 1'b1;
        #1;
        cmp_cnt++; if (fetchRespValid !== 1'b1) begin err_cnt++; $display("FAIL fp_fetchRespValid got %0h want 1", fetchRespValid); end
        cmp_cnt++; if (pfRespValid !== 1'b0) begin err_cnt++; $display("FAIL fp_pfRespValid got %0h want 0", pfRespValid); end
        cmp_cnt++; if (respHit !== 1'b1) begin err_cnt++; $display("FAIL fp_respHit1 got %0h want 1", respHit); end
        icReadHit = 1'b0;
        #1;
        cmp_cnt++; if (respHit !== 1'b0) begin err_cnt++; $display("FAIL fp_respHit0 got %0h want 0", respHit); end
        tick();
    endtask

    task automatic test_redundant_drop();
        logic [3:0] exp_cnt;
`ifdef ICACHE_ARB_ANTI_STARVE_EN
        exp_cnt = 4'd1;
`else
        exp_cnt = 4'd0;
`endif
        // Fetch wins at 0x1004 while an unrelated prefetch loses one cycle.
        fetchReq = 1'b1; fetchAddr = 32'h0000_1004;
        pfReq = 1'b1; pfAddr = 32'h0000_5000;
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b1) begin err_cnt++; $display("FAIL rd_fetchGrant got %0h want 1", fetchGrant); end
        tick();
        cmp_cnt++; if (dut.starveCnt !== exp_cnt) begin err_cnt++; $display("FAIL rd_cnt_before got %0d want %0d", dut.starveCnt, exp_cnt); end
        fetchReq = 1'b0; pfAddr = 32'h0000_100C;
        #1;
        cmp_cnt++; if (pfDropped !== 1'b1) begin err_cnt++; $display("FAIL rd_pfDropped got %0h want 1", pfDropped); end
        cmp_cnt++; if (pfGrant !== 1'b0) begin err_cnt++; $display("FAIL rd_pfGrant got %0h want 0", pfGrant); end
        cmp_cnt++; if (icRE !== 1'b0) begin err_cnt++; $display("FAIL rd_icRE got %0h want 0", icRE); end
        tick();
        cmp_cnt++; if (dut.starveCnt !== exp_cnt) begin err_cnt++; $display("FAIL rd_cnt_after got %0d want %0d", dut.starveCnt, exp_cnt); end
        idle();
        tick();
        // Same-cycle variant: fetch is reading the line right now.
        fetchReq = 1'b1; fetchAddr = 32'h0000_2000;
        pfReq = 1'b1; pfAddr = 32'h0000_2008;
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b1) begin err_cnt++; $display("FAIL rd2_fetchGrant got %0h want 1", fetchGrant); end
        cmp_cnt++; if (pfDropped !== 1'b1) begin err_cnt++; $display("FAIL rd2_pfDropped got %0h want 1", pfDropped); end
        cmp_cnt++; if (pfGrant !== 1'b0) begin err_cnt++; $display("FAIL rd2_pfGrant got %0h want 0", pfGrant); end
        tick();
        cmp_cnt++; if (dut.starveCnt !== 4'd0) begin err_cnt++; $display("FAIL rd2_cnt got %0d want 0", dut.starveCnt); end
        idle();
        tick();
    endtask

    task automatic test_starvation();
        logic exp_pf;
        fetchReq = 1'b1; fetchAddr = 32'h0000_1000;
        pfReq = 1'b1; pfAddr = 32'h0000_3000;
        for (int c = 1; c <= 20; c++) begin
`ifdef ICACHE_ARB_ANTI_STARVE_EN
            exp_pf = (c == 9) || (c == 18);
`else
            exp_pf = 1'b0;
`endif
            #1;
            cmp_cnt++; if (pfGrant !== exp_pf) begin err_cnt++; $display("FAIL st_pfGrant c%0d got %0h want %0h", c, pfGrant, exp_pf); end
            cmp_cnt++; if (fetchGrant !== !exp_pf) begin err_cnt++; $display("FAIL st_fetchGrant c%0d got %0h want %0h", c, fetchGrant, !exp_pf); end
            if (c == 10) begin
                cmp_cnt++; if (dut.starveCnt !== 4'd0) begin err_cnt++; $display("FAIL st_cnt_cleared got %0d want 0", dut.starveCnt); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        // Cycle N: prefetch granted alone.
        fetchReq = 1'b0;
        pfReq = 1'b1; pfAddr = 32'h0000_4000;
        #1;
        cmp_cnt++; if (pfGrant !== 1'b1) begin err_cnt++; $display("FAIL fl_pfGrant got %0h want 1", pfGrant); end
        cmp_cnt++; if (icReadAddrIn !== 32'h0000_4000) begin err_cnt++; $display("FAIL fl_addr got %0h want 4000", icReadAddrIn); end
        tick();
        // Cycle N+1: flush with both requesting.
        flush = 1'b1;
        fetchReq = 1'b1; fetchAddr = 32'h0000_6000;
        pfReq = 1'b1; pfAddr = 32'h0000_7000;
        #1;
        cmp_cnt++; if (pfRespValid !== 1'b0) begin err_cnt++; $display("FAIL fl_pfRespValid got %0h want 0", pfRespValid); end
        cmp_cnt++; if (fetchGrant !== 1'b0) begin err_cnt++; $display("FAIL fl_fetchGrant got %0h want 0", fetchGrant); end
        cmp_cnt++; if (pfGrant !== 1'b0) begin err_cnt++; $display("FAIL fl_pfGrant_n1 got %0h want 0", pfGrant); end
        cmp_cnt++; if (icRE !== 1'b0) begin err_cnt++; $display("FAIL fl_icRE got %0h want 0", icRE); end
        cmp_cnt++; if (pfDropped !== 1'b0) begin err_cnt++; $display("FAIL fl_pfDropped got %0h want 0", pfDropped); end
        tick();
        cmp_cnt++; if (dut.lastLineValid !== 1'b0) begin err_cnt++; $display("FAIL fl_lastLineValid got %0h want 0", dut.lastLineValid); end
        // Prefetch to the last fetched line (0x100) now goes through.
        flush = 1'b0; fetchReq = 1'b0;
        pfReq = 1'b1; pfAddr = 32'h0000_1008;
        #1;
        cmp_cnt++; if (pfGrant !== 1'b1) begin err_cnt++; $display("FAIL fl_post_pfGrant got %0h want 1", pfGrant); end
        cmp_cnt++; if (pfDropped !== 1'b0) begin err_cnt++; $display("FAIL fl_post_pfDropped got %0h want 0", pfDropped); end
        tick();
        idle();
        #1;
        cmp_cnt++; if (pfRespValid !== 1'b1) begin err_cnt++; $display("FAIL fl_post_pfRespValid got %0h want 1", pfRespValid); end
        tick();
    endtask

    task automatic test_reset_mid();
        // Cycle N: fetch granted, prefetch loses a cycle.
        fetchReq = 1'b1; fetchAddr = 32'h0000_8000;
        pfReq = 1'b1; pfAddr = 32'h0000_9000;
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b1) begin err_cnt++; $display("FAIL rm_fetchGrant got %0h want 1", fetchGrant); end
        tick();
        // Cycle N+1: reset asserted.
        rst = 1'b0;
        #1;
        cmp_cnt++; if (fetchRespValid !== 1'b0) begin err_cnt++; $display("FAIL rm_fetchRespValid got %0h want 0", fetchRespValid); end
        cmp_cnt++; if (pfRespValid !== 1'b0) begin err_cnt++; $display("FAIL rm_pfRespValid got %0h want 0", pfRespValid); end
        cmp_cnt++; if (icRE !== 1'b0) begin err_cnt++; $display("FAIL rm_icRE got %0h want 0", icRE); end
        tick();
        cmp_cnt++; if (dut.starveCnt !== 4'd0) begin err_cnt++; $display("FAIL rm_starveCnt got %0d want 0", dut.starveCnt); end
        rst = 1'b1;
        fetchReq = 1'b0;
        pfReq = 1'b1; pfAddr = 32'h0000_8004;
        #1;
        cmp_cnt++; if (fetchRespValid !== 1'b0) begin err_cnt++; $display("FAIL rm_post_fetchRespValid got %0h want 0", fetchRespValid); end
        cmp_cnt++; if (pfDropped !== 1'b0) begin err_cnt++; $display("FAIL rm_post_pfDropped got %0h want 0", pfDropped); end
        cmp_cnt++; if (pfGrant !== 1'b1) begin err_cnt++; $display("FAIL rm_post_pfGrant got %0h want 1", pfGrant); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        fetchReq = 1'b1; fetchAddr = 32'h0000_A000; pfReq = 1'b0;
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b1) begin err_cnt++; $display("FAIL bb_fetchGrant0 got %0h want 1", fetchGrant); end
        tick();
        fetchReq = 1'b0; pfReq = 1'b1; pfAddr = 32'h0000_B000;
        #1;
        cmp_cnt++; if (pfGrant !== 1'b1) begin err_cnt++; $display("FAIL bb_pfGrant1 got %0h want 1", pfGrant); end
        cmp_cnt++; if (icReadAddrIn !== 32'h0000_B000) begin err_cnt++; $display("FAIL bb_addr1 got %0h want b000", icReadAddrIn); end
        cmp_cnt++; if (fetchRespValid !== 1'b1) begin err_cnt++; $display("FAIL bb_fetchRespValid1 got %0h want 1", fetchRespValid); end
        tick();
        fetchReq = 1'b1; fetchAddr = 32'h0000_C000; pfReq = 1'b0;
        #1;
        cmp_cnt++; if (fetchGrant !== 1'b1) begin err_cnt++; $display("FAIL bb_fetchGrant2 got %0h want 1", fetchGrant); end
        cmp_cnt++; if (pfRespValid !== 1'b1) begin err_cnt++; $display("FAIL bb_pfRespValid2 got %0h want 1", pfRespValid); end
        cmp_cnt++; if (fetchRespValid !== 1'b0) begin err_cnt++; $display("FAIL bb_fetchRespValid2 got %0h want 0", fetchRespValid); end
        tick();
        idle();
        tick();
    endtask

    initial begin
        fetchAddr = '0;
        pfAddr    = '0;
        test_reset();
        test_fetch_priority();
        test_redundant_drop();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
